// File: rtl/ip_hdr_tx.sv
// IPv4 header generator: latches a request, computes the header checksum
// over ten cycles plus two folds, then streams 20 header bytes.
module ip_hdr_tx #(
  parameter logic [7:0]  TTL     = 8'd64,
  parameter logic [15:0] ID_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] payload_len,
  input  logic [7:0]  protocol,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic        busy,
  output logic [7:0]  hdr_data,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic        hdr_last,
  output logic [15:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FOLD,
    S_SEND
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] id_cnt_q, id_cnt_d;
  logic [15:0] id_q, id_d;
  logic [15:0] tlen_q, tlen_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  w_q, w_d;
  logic [4:0]  b_q, b_d;
  logic [15:0] csum_q, csum_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;

  logic [4:0]  nb;
  logic [15:0] nword;
  logic [7:0]  nbyte;
  logic [15:0] cword;
  logic [19:0] fold;

  function automatic logic [15:0] hword(
    input logic [3:0]  w,
    input logic [15:0] tl,
    input logic [15:0] id,
    input logic [7:0]  pr,
    input logic [31:0] s,
    input logic [31:0] d,
    input logic [15:0] cs
  );
    logic [15:0] r;
    r = 16'h0000;
    case (w)
      4'd0:    r = 16'h4500;
      4'd1:    r = tl;
      4'd2:    r = id;
      4'd3:    r = 16'h4000;
      4'd4:    r = {TTL, pr};
      4'd5:    r = cs;
      4'd6:    r = s[31:16];
      4'd7:    r = s[15:0];
      4'd8:    r = d[31:16];
      4'd9:    r = d[15:0];
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  always_comb begin
    nb    = b_q + 5'd1;
    nword = hword(nb[4:1], tlen_q, id_q, proto_q,
                  src_q, dst_q, csum_q);
    nbyte = nb[0] ? nword[7:0] : nword[15:8];
    // checksum field counts as zero while summing
    cword = hword(w_q, tlen_q, id_q, proto_q,
                  src_q, dst_q, 16'h0000);
    fold  = {4'h0, acc_q[15:0]} + {16'h0, acc_q[19:16]};

    state_d  = state_q;
    id_cnt_d = id_cnt_q;
    id_d     = id_q;
    tlen_d   = tlen_q;
    proto_d  = proto_q;
    src_d    = src_q;
    dst_d    = dst_q;
    acc_d    = acc_q;
    w_d      = w_q;
    b_d      = b_q;
    csum_d   = csum_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tlen_d   = payload_len + 16'd20;
          proto_d  = protocol;
          src_d    = src_ip;
          dst_d    = dst_ip;
          id_d     = id_cnt_q;
          id_cnt_d = id_cnt_q + 16'd1;
          acc_d    = 20'h0;
          w_d      = 4'd0;
          busy_d   = 1'b1;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_q + {4'h0, cword};
        w_d   = w_q + 4'd1;
        if (w_q == 4'd9) begin
          w_d     = 4'd0;
          state_d = S_FOLD;
        end
      end
      S_FOLD: begin
        acc_d = fold;
        w_d   = w_q + 4'd1;
        if (w_q == 4'd1) begin
          csum_d  = ~fold[15:0];
          b_d     = 5'd0;
          data_d  = 8'h45;
          valid_d = 1'b1;
          last_d  = 1'b0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (hdr_ready) begin
          if (b_q == 5'd19) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            b_d    = nb;
            data_d = nbyte;
            last_d = (nb == 5'd19);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      id_cnt_q <= ID_INIT;
      id_q     <= 16'h0;
      tlen_q   <= 16'h0;
      proto_q  <= 8'h0;
      src_q    <= 32'h0;
      dst_q    <= 32'h0;
      acc_q    <= 20'h0;
      w_q      <= 4'd0;
      b_q      <= 5'd0;
      csum_q   <= 16'h0;
      data_q   <= 8'h0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_cnt_q <= id_cnt_d;
      id_q     <= id_d;
      tlen_q   <= tlen_d;
      proto_q  <= proto_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      acc_q    <= acc_d;
      w_q      <= w_d;
      b_q      <= b_d;
      csum_q   <= csum_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign hdr_data  = data_q;
  assign hdr_valid = valid_q;
  assign hdr_last  = last_q;
  assign checksum  = csum_q;

endmodule
